// File: rtl/fc_apu_dispatcher.sv
// Issue-side dispatcher for a shared APU: one request register, a tag FIFO for
// granted-but-unanswered ops, registered writeback and sticky status flags.
module fc_apu_dispatcher #(
  parameter int NARGS     = 3,
  parameter int WOP       = 6,
  parameter int NDSFLAGS  = 15,
  parameter int NUSFLAGS  = 5,
  parameter int MAX_OUTST = 2,
  parameter int TAG_W     = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              op_valid_i,
  output logic                              op_ready_o,
  input  logic [NARGS-1:0][31:0]            op_operands_i,
  input  logic [WOP-1:0]                    op_op_i,
  input  logic [NDSFLAGS-1:0]               op_flags_i,
  input  logic [TAG_W-1:0]                  op_tag_i,
  output logic                              apu_req_o,
  input  logic                              apu_gnt_i,
  output logic [NARGS-1:0][31:0]            apu_operands_o,
  output logic [WOP-1:0]                    apu_op_o,
  output logic [NDSFLAGS-1:0]               apu_flags_o,
  input  logic                              apu_rvalid_i,
  input  logic [31:0]                       apu_rdata_i,
  input  logic [NUSFLAGS-1:0]               apu_rflags_i,
  output logic                              wb_valid_o,
  output logic [TAG_W-1:0]                  wb_tag_o,
  output logic [31:0]                       wb_data_o,
  output logic [NUSFLAGS-1:0]               wb_flags_o,
  output logic [$clog2(MAX_OUTST+1)-1:0]    outst_o,
  output logic                              busy_o,
  output logic [NUSFLAGS-1:0]               fflags_o,
  input  logic                              fflags_clr_i,
  output logic                              err_o
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  state_e                          r_state;
  logic [NARGS-1:0][31:0]          r_operands;
  logic [WOP-1:0]                  r_op;
  logic [NDSFLAGS-1:0]             r_flags;
  logic [TAG_W-1:0]                r_tag;
  logic [MAX_OUTST-1:0][TAG_W-1:0] r_tagq;
  logic [PW-1:0]                   r_wr_ptr;
  logic [PW-1:0]                   r_rd_ptr;
  logic [OW-1:0]                   r_outst;
  logic                            r_wb_valid;
  logic [TAG_W-1:0]                r_wb_tag;
  logic [31:0]                     r_wb_data;
  logic [NUSFLAGS-1:0]             r_wb_flags;
  logic [NUSFLAGS-1:0]             r_fflags;
  logic                            r_err;

  logic w_accept, w_push, w_pop, w_empty;

  assign w_empty    = (r_outst == '0);
  assign op_ready_o = (r_state == IDLE) && (r_outst < OW'(MAX_OUTST));
  assign apu_req_o  = (r_state == REQ);
  assign w_accept   = op_valid_i && op_ready_o;
  // Grant is only meaningful while a request is on the bus.
  assign w_push     = apu_req_o && apu_gnt_i;
  assign w_pop      = apu_rvalid_i && !w_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_operands <= '0;
      r_op       <= '0;
      r_flags    <= '0;
      r_tag      <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state    <= REQ;
          r_operands <= op_operands_i;
          r_op       <= op_op_i;
          r_flags    <= op_flags_i;
          r_tag      <= op_tag_i;
        end
        REQ: if (apu_gnt_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag FIFO; a new op is only accepted below capacity, so a push never overflows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tagq   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_outst  <= '0;
    end else begin
      if (w_push) begin
        r_tagq[r_wr_ptr] <= r_tag;
        r_wr_ptr <= (r_wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_outst <= r_outst + 1'b1;
      else if (w_pop && !w_push) r_outst <= r_outst - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_data  <= '0;
      r_wb_flags <= '0;
      r_fflags   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= w_pop;
      if (w_pop) begin
        r_wb_tag   <= r_tagq[r_rd_ptr];
        r_wb_data  <= apu_rdata_i;
        r_wb_flags <= apu_rflags_i;
      end
      // A clear coinciding with a response keeps only the new response's flags.
      if (fflags_clr_i) r_fflags <= w_pop ? apu_rflags_i : '0;
      else if (w_pop)   r_fflags <= r_fflags | apu_rflags_i;
      if (apu_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end

  assign apu_operands_o = r_operands;
  assign apu_op_o       = r_op;
  assign apu_flags_o    = r_flags;
  assign wb_valid_o     = r_wb_valid;
  assign wb_tag_o       = r_wb_tag;
  assign wb_data_o      = r_wb_data;
  assign wb_flags_o     = r_wb_flags;
  assign outst_o        = r_outst;
  assign busy_o         = (r_state != IDLE) || (r_outst != '0);
  assign fflags_o       = r_fflags;
  assign err_o          = r_err;

endmodule

// File: tb/tb_fc_apu_dispatcher.sv
// Directed bench for fc_apu_dispatcher: single op, grant stall, FIFO fill,
// sticky flags, spurious response and mid-operation reset.
module tb_fc_apu_dispatcher;
  localparam int NARGS = 3, WOP = 6, NDS = 15, NUS = 5, MAXO = 2, TW = 5;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  op_valid_i, op_ready_o;
  logic [NARGS-1:0][31:0] op_operands_i, apu_operands_o;
  logic [WOP-1:0]        op_op_i, apu_op_o;
  logic [NDS-1:0]        op_flags_i, apu_flags_o;
  logic [TW-1:0]         op_tag_i, wb_tag_o;
  logic                  apu_req_o, apu_gnt_i, apu_rvalid_i;
  logic [31:0]           apu_rdata_i, wb_data_o;
  logic [NUS-1:0]        apu_rflags_i, wb_flags_o, fflags_o;
  logic                  wb_valid_o, busy_o, fflags_clr_i, err_o;
  logic [1:0]            outst_o;

  int n_chk = 0;
  int n_fail = 0;

  fc_apu_dispatcher #(.NARGS(NARGS), .WOP(WOP), .NDSFLAGS(NDS), .NUSFLAGS(NUS),
                      .MAX_OUTST(MAXO), .TAG_W(TW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_operands_i(op_operands_i), .op_op_i(op_op_i), .op_flags_i(op_flags_i),
    .op_tag_i(op_tag_i),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
    .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
    .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
    .wb_valid_o(wb_valid_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o),
    .wb_flags_o(wb_flags_o), .outst_o(outst_o), .busy_o(busy_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [TW-1:0] tag, input logic [WOP-1:0] op, input logic [31:0] a0);
    op_valid_i       = 1'b1;
    op_tag_i         = tag;
    op_op_i          = op;
    op_operands_i[0] = a0;
    op_operands_i[1] = a0 ^ 32'h5555_0000;
    op_operands_i[2] = ~a0;
    op_flags_i       = NDS'(15'h1234);
  endtask

  task automatic resp(input logic [31:0] d, input logic [NUS-1:0] f);
    apu_rvalid_i = 1'b1;
    apu_rdata_i  = d;
    apu_rflags_i = f;
  endtask

  initial begin
    rst_ni = 1'b0; op_valid_i = 0; op_operands_i = '0; op_op_i = '0; op_flags_i = '0;
    op_tag_i = '0; apu_gnt_i = 0; apu_rvalid_i = 0; apu_rdata_i = '0; apu_rflags_i = '0;
    fflags_clr_i = 0;
    #23;
    chk("rst_req", apu_req_o, 0);
    chk("rst_wbv", wb_valid_o, 0);
    chk("rst_outst", outst_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    step();
    chk("rst_ready", op_ready_o, 1);

    // Single op, tag 7, grant on first request cycle, response 3 cycles later.
    issue(7, 6'h2A, 32'h1111_2222);
    step();
    op_valid_i = 0;
    chk("s_req", apu_req_o, 1);
    chk("s_op", apu_op_o, 32'h2A);
    chk("s_opnd2", apu_operands_o[2], 32'hEEEE_DDDD);
    chk("s_ready", op_ready_o, 0);
    apu_gnt_i = 1;
    step();
    apu_gnt_i = 0;
    chk("s_idle", apu_req_o, 0);
    chk("s_outst1", outst_o, 1);
    chk("s_busy", busy_o, 1);
    step(); step();
    resp(32'h3F80_0000, 5'h01);
    step();
    apu_rvalid_i = 0;
    chk("s_wbv", wb_valid_o, 1);
    chk("s_wbtag", wb_tag_o, 7);
    chk("s_wbdata", wb_data_o, 32'h3F80_0000);
    chk("s_fflags", fflags_o, 5'h01);
    chk("s_outst0", outst_o, 0);
    step();
    chk("s_pulse", wb_valid_o, 0);
    chk("s_hold", wb_data_o, 32'h3F80_0000);
    fflags_clr_i = 1;
    step();
    fflags_clr_i = 0;
    chk("clr", fflags_o, 0);

    // Grant stall for 4 cycles; stray grant beforehand must be ignored.
    apu_gnt_i = 1;
    step();
    chk("gnt_ign", outst_o, 0);
    apu_gnt_i = 0;
    issue(4, 6'h15, 32'hCAFE_0001);
    step();
    op_valid_i = 0;
    op_op_i = 6'h3F; op_operands_i = '1;
    for (int i = 0; i < 4; i++) begin
      chk("st_req", apu_req_o, 1);
      chk("st_op", apu_op_o, 32'h15);
      chk("st_opnd", apu_operands_o[0], 32'hCAFE_0001);
      chk("st_ready", op_ready_o, 0);
      step();
    end
    apu_gnt_i = 1;
    step();
    apu_gnt_i = 0;
    chk("st_idle", apu_req_o, 0);
    chk("st_outst", outst_o, 1);
    resp(32'h0000_00AB, 5'h00);
    step();
    apu_rvalid_i = 0;
    chk("st_wbtag", wb_tag_o, 4);
    chk("st_outst0", outst_o, 0);

    // Fill: tags 1,2 granted, tag 3 blocked until a response pops.
    issue(1, 6'h01, 32'h1);
    step();
    apu_gnt_i = 1; op_valid_i = 0;
    step();
    apu_gnt_i = 0;
    issue(2, 6'h02, 32'h2);
    step();
    apu_gnt_i = 1; op_valid_i = 0;
    step();
    apu_gnt_i = 0;
    chk("f_outst2", outst_o, 2);
    chk("f_ready0", op_ready_o, 0);
    issue(3, 6'h03, 32'h3);
    step();
    chk("f_blocked", apu_req_o, 0);
    chk("f_ready0b", op_ready_o, 0);
    resp(32'hD1, 5'h04);
    step();
    apu_rvalid_i = 0;
    chk("f_wbtag1", wb_tag_o, 1);
    chk("f_outst1", outst_o, 1);
    chk("f_ready1", op_ready_o, 1);
    step();
    op_valid_i = 0;
    chk("f_acc3", apu_req_o, 1);
    chk("f_op3", apu_op_o, 32'h03);
    apu_gnt_i = 1;
    step();
    apu_gnt_i = 0;
    chk("f_outst2b", outst_o, 2);
    resp(32'hD2, 5'h10);
    step();
    chk("f_wbtag2", wb_tag_o, 2);
    chk("fl_or", fflags_o, 5'h14);
    resp(32'hD3, 5'h02);
    fflags_clr_i = 1;
    step();
    apu_rvalid_i = 0; fflags_clr_i = 0;
    chk("f_wbtag3", wb_tag_o, 3);
    chk("f_wbdata3", wb_data_o, 32'hD3);
    chk("fl_clrresp", fflags_o, 5'h02);
    chk("f_outst0", outst_o, 0);

    // Zero-latency unit: response the cycle right after the grant.
    issue(9, 6'h09, 32'h9);
    step();
    op_valid_i = 0; apu_gnt_i = 1;
    step();
    apu_gnt_i = 0;
    resp(32'h99, 5'h00);
    step();
    apu_rvalid_i = 0;
    chk("z_wbv", wb_valid_o, 1);
    chk("z_wbtag", wb_tag_o, 9);
    chk("z_outst", outst_o, 0);

    // Spurious response with nothing outstanding.
    step();
    resp(32'hBAD, 5'h1F);
    step();
    apu_rvalid_i = 0;
    chk("sp_err", err_o, 1);
    chk("sp_wbv", wb_valid_o, 0);
    chk("sp_outst", outst_o, 0);
    chk("sp_fflags", fflags_o, 5'h02);
    step();
    chk("sp_sticky", err_o, 1);

    // Reset in REQ with one tag outstanding.
    issue(5, 6'h05, 32'h5);
    step();
    op_valid_i = 0; apu_gnt_i = 1;
    step();
    apu_gnt_i = 0;
    issue(6, 6'h06, 32'h6);
    step();
    op_valid_i = 0;
    chk("r_pre_req", apu_req_o, 1);
    chk("r_pre_outst", outst_o, 1);
    rst_ni = 0;
    #1;
    chk("r_req", apu_req_o, 0);
    chk("r_op", apu_op_o, 0);
    chk("r_outst", outst_o, 0);
    chk("r_err", err_o, 0);
    chk("r_fflags", fflags_o, 0);
    chk("r_wbtag", wb_tag_o, 0);
    chk("r_wbdata", wb_data_o, 0);
    rst_ni = 1;
    step();
    chk("r_ready", op_ready_o, 1);
    resp(32'h77, 5'h01);
    step();
    apu_rvalid_i = 0;
    chk("r_late_err", err_o, 1);
    chk("r_late_wbv", wb_valid_o, 0);
    chk("r_late_outst", outst_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
